// File: rtl/vend_pkg.sv
// vend_pkg: shared state type, coin values and price/credit constants for the vending sequencer.
package vend_pkg;
  typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_e;
  localparam int COIN5_VAL = 5;
  localparam int COIN10_VAL = 10;
  function automatic int default_price(input int i);
    return 5 * (i + 1);
  endfunction
  function automatic int cmax(input int w);
    return (((1 << w) - 1) / 5) * 5;
  endfunction
endpackage

// File: rtl/vend_sequencer_if.sv
// vend_sequencer_if: coin/keypad/config inputs, dispenser handshake and status outputs.
interface vend_sequencer_if #(parameter int IDX_W = 2, parameter int CREDIT_W = 8);
  logic coin5, coin10, sel_valid, cancel, cfg_we, disp_ack;
  logic disp_req, change5, busy, short, fault;
  logic [IDX_W-1:0] sel_idx, cfg_idx, disp_idx;
  logic [CREDIT_W-1:0] cfg_price, credit;
  modport master(output coin5, coin10, sel_valid, sel_idx, cancel, cfg_we, cfg_idx, cfg_price, disp_ack,
                 input disp_req, disp_idx, change5, credit, busy, short, fault);
  modport slave(input coin5, coin10, sel_valid, sel_idx, cancel, cfg_we, cfg_idx, cfg_price, disp_ack,
                output disp_req, disp_idx, change5, credit, busy, short, fault);
endinterface

// File: rtl/vend_price_table.sv
// vend_price_table: per-item price registers with reset defaults, validated writes and a combinational read.
module vend_price_table
  import vend_pkg::*;
#(
  parameter int NUM_ITEMS = 4,
  parameter int IDX_W = 2,
  parameter int CREDIT_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we_i,
  input  logic [IDX_W-1:0]    widx_i,
  input  logic [CREDIT_W-1:0] wprice_i,
  input  logic [IDX_W-1:0]    ridx_i,
  output logic [CREDIT_W-1:0] rprice_o,
  output logic                rvalid_o
);
  logic [CREDIT_W-1:0] price_q [NUM_ITEMS];
  logic wr_ok;
  assign wr_ok = we_i && (int'(widx_i) < NUM_ITEMS) && ((wprice_i % CREDIT_W'(5)) == '0);
  assign rvalid_o = int'(ridx_i) < NUM_ITEMS;
  assign rprice_o = rvalid_o ? price_q[ridx_i] : '1;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ITEMS; i++) price_q[i] <= CREDIT_W'(default_price(i));
    end else if (wr_ok) begin
      price_q[widx_i] <= wprice_i;
    end
  end
endmodule

// File: rtl/vend_sequencer.sv
// vend_sequencer: credit accumulation, price check, dispenser handshake with timeout refund,
// and change return as alternating 5-unit coin pulses.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int NUM_ITEMS = 4,
  parameter int CREDIT_W = 8,
  parameter int DISP_TIMEOUT = 16
) (
  input logic clk,
  input logic reset,
  vend_sequencer_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_ITEMS);
  localparam int TMR_W = $clog2(DISP_TIMEOUT + 1);
  localparam logic [CREDIT_W:0] CMAX = (CREDIT_W + 1)'(cmax(CREDIT_W));
  state_e state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d, paid_q, paid_d, price;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [IDX_W-1:0] disp_idx_q, disp_idx_d;
  logic disp_req_q, disp_req_d, change5_q, change5_d, short_q, short_d, fault_q, fault_d, busy_q, busy_d;
  logic price_ok, sel_ok;
  logic [CREDIT_W:0] coin, credit_x;
  function automatic logic [CREDIT_W-1:0] sat(input logic [CREDIT_W:0] v);
    return (v > CMAX) ? CMAX[CREDIT_W-1:0] : v[CREDIT_W-1:0];
  endfunction
  vend_price_table #(.NUM_ITEMS(NUM_ITEMS), .IDX_W(IDX_W), .CREDIT_W(CREDIT_W)) u_prices (
    .clk(clk), .reset(reset), .we_i(bus.cfg_we), .widx_i(bus.cfg_idx), .wprice_i(bus.cfg_price),
    .ridx_i(bus.sel_idx), .rprice_o(price), .rvalid_o(price_ok)
  );
  assign coin = (bus.coin5 ? (CREDIT_W + 1)'(COIN5_VAL) : '0) + (bus.coin10 ? (CREDIT_W + 1)'(COIN10_VAL) : '0);
  assign credit_x = {1'b0, credit_q};
  // Price check uses credit registered before this cycle's coins.
  assign sel_ok = price_ok && (credit_q >= price);
  always_comb begin
    state_d = state_q;
    credit_d = credit_q;
    paid_d = paid_q;
    tmr_d = tmr_q;
    disp_req_d = disp_req_q;
    disp_idx_d = disp_idx_q;
    change5_d = 1'b0;
    short_d = 1'b0;
    fault_d = 1'b0;
    case (state_q)
      IDLE, CREDIT: begin
        credit_d = sat(credit_x + coin);
        if (bus.cancel) begin
          if (state_q == CREDIT) begin
            state_d = CHANGE;
            change5_d = 1'b1;
          end
        end else if (bus.sel_valid && sel_ok) begin
          state_d = VEND;
          credit_d = sat(credit_x + coin - {1'b0, price});
          paid_d = price;
          tmr_d = '0;
          disp_req_d = 1'b1;
          disp_idx_d = bus.sel_idx;
        end else if (bus.sel_valid) begin
          short_d = 1'b1;
        end
        if (state_d == IDLE || state_d == CREDIT) state_d = (credit_d == '0) ? IDLE : CREDIT;
      end
      VEND: begin
        tmr_d = tmr_q + TMR_W'(1);
        if (bus.disp_ack) begin
          disp_req_d = 1'b0;
          state_d = (credit_q != '0) ? CHANGE : IDLE;
          change5_d = credit_q != '0;
        end else if (tmr_q == TMR_W'(DISP_TIMEOUT - 1)) begin
          disp_req_d = 1'b0;
          fault_d = 1'b1;
          credit_d = sat(credit_x + {1'b0, paid_q});
          state_d = CHANGE;
          change5_d = credit_d != '0;
        end
      end
      default: begin
        if (change5_q) begin
          credit_d = credit_q - CREDIT_W'(COIN5_VAL);
          if (credit_d == '0) state_d = IDLE;
        end else if (credit_q == '0) begin
          state_d = IDLE;
        end else begin
          change5_d = 1'b1;
        end
      end
    endcase
    busy_d = (state_d == VEND) || (state_d == CHANGE);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      credit_q <= '0;
      paid_q <= '0;
      tmr_q <= '0;
      disp_req_q <= 1'b0;
      disp_idx_q <= '0;
      change5_q <= 1'b0;
      short_q <= 1'b0;
      fault_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      credit_q <= credit_d;
      paid_q <= paid_d;
      tmr_q <= tmr_d;
      disp_req_q <= disp_req_d;
      disp_idx_q <= disp_idx_d;
      change5_q <= change5_d;
      short_q <= short_d;
      fault_q <= fault_d;
      busy_q <= busy_d;
    end
  end
  assign bus.disp_req = disp_req_q;
  assign bus.disp_idx = disp_idx_q;
  assign bus.change5 = change5_q;
  assign bus.credit = credit_q;
  assign bus.busy = busy_q;
  assign bus.short = short_q;
  assign bus.fault = fault_q;
endmodule

// File: tb/tb_vend_sequencer.sv
// tb_vend_sequencer: scenario tasks drive the sequencer; a negedge monitor scores dispense and change pulses.
module tb_vend_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int chg_q[$];
  int disp_q[$];
  int e_chg, e_disp;
  logic prev_req = 1'b0;
  logic prev_chg = 1'b0;
  vend_sequencer_if #(.IDX_W(2), .CREDIT_W(8)) bus();
  vend_sequencer #(.NUM_ITEMS(4), .CREDIT_W(8), .DISP_TIMEOUT(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (!reset && bus.change5) begin
      checks++;
      if (chg_q.size() == 0) begin
        errors++;
        $display("FAIL change5_unexpected: pulse at credit=%0d, none expected", bus.credit);
      end else begin
        e_chg = chg_q.pop_front();
        if (bus.credit !== 8'(e_chg)) begin
          errors++;
          $display("FAIL change5_credit: credit=%0d during pulse, expected %0d", bus.credit, e_chg);
        end
      end
    end
    if (!reset && bus.busy && !bus.disp_req) begin
      checks++;
      if (bus.change5 === prev_chg) begin
        errors++;
        $display("FAIL change5_spacing: change5=%0b twice in a row, expected alternation", bus.change5);
      end
    end
    if (!reset && bus.disp_req && !prev_req) begin
      checks++;
      if (disp_q.size() == 0) begin
        errors++;
        $display("FAIL disp_unexpected: disp_req rose with idx=%0d, no vend expected", bus.disp_idx);
      end else begin
        e_disp = disp_q.pop_front();
        if (bus.disp_idx !== 2'(e_disp)) begin
          errors++;
          $display("FAIL disp_idx: got %0d expected %0d", bus.disp_idx, e_disp);
        end
      end
    end
    prev_chg <= bus.change5;
    prev_req <= bus.disp_req;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs();
    bus.coin5 = 0; bus.coin10 = 0; bus.sel_valid = 0; bus.sel_idx = 0; bus.cancel = 0;
    bus.cfg_we = 0; bus.cfg_idx = 0; bus.cfg_price = 0; bus.disp_ack = 0;
  endtask
  task automatic coin(input logic c5, input logic c10);
    bus.coin5 = c5; bus.coin10 = c10;
    tick();
    bus.coin5 = 0; bus.coin10 = 0;
  endtask
  task automatic select(input int idx, input logic exp_ok);
    if (exp_ok) disp_q.push_back(idx);
    bus.sel_valid = 1; bus.sel_idx = 2'(idx);
    tick();
    bus.sel_valid = 0;
  endtask
  task automatic ack_after(input int n);
    repeat (n) tick();
    bus.disp_ack = 1;
    tick();
    bus.disp_ack = 0;
  endtask
  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int n = 0; n < 80; n++) begin
      if (!bus.busy) begin ok = 1; break; end
      tick();
    end
  endtask
  task automatic test_reset();
    idle_inputs();
    repeat (2) tick();
    checks++;
    if ({bus.disp_req, bus.change5, bus.busy, bus.short, bus.fault, bus.credit} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: req/chg/busy/short/fault/credit=%b, expected all zero",
               {bus.disp_req, bus.change5, bus.busy, bus.short, bus.fault, bus.credit});
    end
    reset = 0;
    tick();
  endtask
  task automatic test_exact_pay();
    bit ok;
    coin(1, 0);
    coin(1, 0);
    checks++;
    if (bus.credit !== 8'd10) begin errors++; $display("FAIL pay_credit: got %0d expected 10", bus.credit); end
    select(1, 1);
    checks++;
    if ({bus.disp_req, bus.busy, bus.credit} !== {2'b11, 8'd0}) begin
      errors++;
      $display("FAIL pay_vend: req=%0b busy=%0b credit=%0d, expected 1 1 0", bus.disp_req, bus.busy, bus.credit);
    end
    ack_after(2);
    checks++;
    if ({bus.disp_req, bus.busy, bus.change5} !== 3'b000) begin
      errors++;
      $display("FAIL pay_ack: req=%0b busy=%0b change5=%0b, expected 0 0 0", bus.disp_req, bus.busy, bus.change5);
    end
    repeat (4) tick();
    wait_idle(ok);
  endtask
  task automatic test_overpay();
    bit ok;
    coin(0, 1);
    coin(0, 1);
    select(0, 1);
    checks++;
    if ({bus.disp_req, bus.credit} !== {1'b1, 8'd15}) begin
      errors++;
      $display("FAIL over_vend: req=%0b credit=%0d, expected 1 15", bus.disp_req, bus.credit);
    end
    chg_q.push_back(15); chg_q.push_back(10); chg_q.push_back(5);
    ack_after(1);
    wait_idle(ok);
    checks++;
    if (!ok || chg_q.size() != 0 || bus.credit !== 8'd0) begin
      errors++;
      $display("FAIL over_change: idle=%0b pending=%0d credit=%0d, expected 1 0 0", ok, chg_q.size(), bus.credit);
    end
  endtask
  task automatic test_short_cancel();
    bit ok;
    coin(1, 0);
    select(3, 0);
    checks++;
    if ({bus.short, bus.disp_req, bus.credit} !== {2'b10, 8'd5}) begin
      errors++;
      $display("FAIL short_pulse: short=%0b req=%0b credit=%0d, expected 1 0 5", bus.short, bus.disp_req, bus.credit);
    end
    tick();
    checks++;
    if (bus.short !== 1'b0) begin errors++; $display("FAIL short_width: short=%0b expected 0", bus.short); end
    chg_q.push_back(5);
    bus.cancel = 1; tick(); bus.cancel = 0;
    wait_idle(ok);
    checks++;
    if (!ok || chg_q.size() != 0 || bus.credit !== 8'd0) begin
      errors++;
      $display("FAIL cancel_change: idle=%0b pending=%0d credit=%0d, expected 1 0 0", ok, chg_q.size(), bus.credit);
    end
    coin(0, 1);
    chg_q.push_back(10); chg_q.push_back(5);
    bus.cancel = 1; bus.sel_valid = 1; bus.sel_idx = 0;
    tick();
    bus.cancel = 0; bus.sel_valid = 0;
    checks++;
    if ({bus.disp_req, bus.busy} !== 2'b01) begin
      errors++;
      $display("FAIL cancel_wins: req=%0b busy=%0b, expected 0 1", bus.disp_req, bus.busy);
    end
    wait_idle(ok);
    checks++;
    if (!ok || chg_q.size() != 0) begin
      errors++;
      $display("FAIL cancel_wins_change: idle=%0b pending=%0d, expected 1 0", ok, chg_q.size());
    end
  endtask
  task automatic test_timeout();
    bit ok;
    int n;
    coin(0, 1);
    select(1, 1);
    chg_q.push_back(10); chg_q.push_back(5);
    coin(1, 0);
    checks++;
    if (bus.credit !== 8'd0) begin errors++; $display("FAIL vend_coin_gate: credit=%0d expected 0", bus.credit); end
    n = 1;
    while (!bus.fault && n < 30) begin tick(); n++; end
    checks++;
    if (n != 16) begin errors++; $display("FAIL timeout_cycles: fault after %0d cycles, expected 16", n); end
    checks++;
    if ({bus.disp_req, bus.credit, bus.change5} !== {1'b0, 8'd10, 1'b1}) begin
      errors++;
      $display("FAIL timeout_refund: req=%0b credit=%0d change5=%0b, expected 0 10 1", bus.disp_req, bus.credit, bus.change5);
    end
    tick();
    checks++;
    if (bus.fault !== 1'b0) begin errors++; $display("FAIL fault_width: fault=%0b expected 0", bus.fault); end
    wait_idle(ok);
    checks++;
    if (!ok || chg_q.size() != 0) begin
      errors++;
      $display("FAIL timeout_change: idle=%0b pending=%0d, expected 1 0", ok, chg_q.size());
    end
  endtask
  task automatic test_ack_at_timeout();
    coin(0, 1);
    select(1, 1);
    repeat (15) tick();
    checks++;
    if (bus.disp_req !== 1'b1) begin errors++; $display("FAIL late_req: req=%0b expected 1", bus.disp_req); end
    bus.disp_ack = 1; tick(); bus.disp_ack = 0;
    checks++;
    if ({bus.fault, bus.disp_req, bus.busy} !== 3'b000) begin
      errors++;
      $display("FAIL late_ack: fault=%0b req=%0b busy=%0b, expected 0 0 0", bus.fault, bus.disp_req, bus.busy);
    end
  endtask
  task automatic test_config();
    bit ok;
    bus.cfg_we = 1; bus.cfg_idx = 2; bus.cfg_price = 8'd25; tick();
    bus.cfg_price = 8'd7; tick();
    bus.cfg_we = 0;
    coin(1, 1);
    coin(0, 1);
    checks++;
    if (bus.credit !== 8'd25) begin errors++; $display("FAIL cfg_credit: got %0d expected 25", bus.credit); end
    select(2, 1);
    checks++;
    if ({bus.disp_req, bus.credit} !== {1'b1, 8'd0}) begin
      errors++;
      $display("FAIL cfg_vend: req=%0b credit=%0d, expected 1 0", bus.disp_req, bus.credit);
    end
    ack_after(0);
    coin(0, 1);
    disp_q.push_back(1);
    bus.cfg_we = 1; bus.cfg_idx = 1; bus.cfg_price = 8'd30;
    bus.sel_valid = 1; bus.sel_idx = 1;
    tick();
    bus.cfg_we = 0; bus.sel_valid = 0;
    checks++;
    if ({bus.disp_req, bus.credit} !== {1'b1, 8'd0}) begin
      errors++;
      $display("FAIL cfg_old_price: req=%0b credit=%0d, expected 1 0", bus.disp_req, bus.credit);
    end
    ack_after(0);
    coin(0, 1);
    select(1, 0);
    checks++;
    if ({bus.short, bus.credit} !== {1'b1, 8'd10}) begin
      errors++;
      $display("FAIL cfg_new_price: short=%0b credit=%0d, expected 1 10", bus.short, bus.credit);
    end
    chg_q.push_back(10); chg_q.push_back(5);
    bus.cancel = 1; tick(); bus.cancel = 0;
    wait_idle(ok);
  endtask
  task automatic test_saturation_reset();
    bit ok;
    repeat (30) coin(0, 1);
    checks++;
    if (bus.credit !== 8'd255) begin errors++; $display("FAIL saturate: credit=%0d expected 255", bus.credit); end
    for (int v = 255; v > 0; v -= 5) chg_q.push_back(v);
    bus.cancel = 1; tick(); bus.cancel = 0;
    repeat (2) tick();
    reset = 1;
    #2;
    checks++;
    if ({bus.disp_req, bus.change5, bus.busy, bus.short, bus.fault, bus.credit} !== 13'd0) begin
      errors++;
      $display("FAIL reset_mid_change: req/chg/busy/short/fault/credit=%b, expected all zero",
               {bus.disp_req, bus.change5, bus.busy, bus.short, bus.fault, bus.credit});
    end
    chg_q.delete();
    tick();
    reset = 0;
    tick();
    repeat (3) coin(1, 0);
    select(2, 1);
    checks++;
    if ({bus.disp_req, bus.credit} !== {1'b1, 8'd0}) begin
      errors++;
      $display("FAIL default_price2: req=%0b credit=%0d, expected 1 0", bus.disp_req, bus.credit);
    end
    ack_after(0);
    coin(0, 1);
    select(1, 1);
    checks++;
    if ({bus.disp_req, bus.credit} !== {1'b1, 8'd0}) begin
      errors++;
      $display("FAIL default_price1: req=%0b credit=%0d, expected 1 0", bus.disp_req, bus.credit);
    end
    ack_after(0);
    wait_idle(ok);
    checks++;
    if (!ok || disp_q.size() != 0) begin
      errors++;
      $display("FAIL final_idle: idle=%0b pending_vends=%0d, expected 1 0", ok, disp_q.size());
    end
  endtask
  initial begin
    test_reset();
    test_exact_pay();
    test_overpay();
    test_short_cancel();
    test_timeout();
    test_ack_at_timeout();
    test_config();
    test_saturation_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
